// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 timer/interrupt unit: register addresses,
// IntCtl field positions, vector offsets and the VS legality check.
package cp0_pkg;

  localparam int CP0_ADDR_W = 5;

  // IntCtl has no sel field on this write bus, so it is given its own slot.
  localparam logic [CP0_ADDR_W-1:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [CP0_ADDR_W-1:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [CP0_ADDR_W-1:0] CP0_REG_INTCTL  = 5'd21;

  localparam int INTCTL_IPTI_LSB = 29;
  localparam int INTCTL_VS_LSB   = 5;

  localparam logic [31:0] VEC_OFF_GENERAL = 32'h0000_0180;
  localparam logic [31:0] VEC_OFF_IV      = 32'h0000_0200;

  function automatic logic vs_legal(input logic [4:0] vs);
    return (vs == 5'd0) || (vs == 5'd1) || (vs == 5'd2) ||
           (vs == 5'd4) || (vs == 5'd8) || (vs == 5'd16);
  endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Multi-flop synchroniser for asynchronous level interrupt lines.
module cp0_int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cp0_intc.sv
// CP0 Count/Compare timer with prescaler, pending-IP register, registered
// priority-encoded interrupt request and IntCtl.VS vector offset.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int NUM_HW_INT  = 6,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_DIV   = 2,
  parameter int TIMER_IP    = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  input  logic [1:0]            sw_int_i,
  input  logic [31:0]           status_i,
  input  logic                  cause_iv_i,
  input  logic                  cause_dc_i,
  input  logic                  we_i,
  input  logic [CP0_ADDR_W-1:0] waddr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic [31:0]           intctl_o,
  output logic [7:0]            ip_o,
  output logic                  timer_int_o,
  output logic                  int_req_o,
  output logic [2:0]            int_num_o,
  output logic [31:0]           vector_offset_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0]         r_presc;
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic                  r_armed;
  logic                  r_timer;
  logic [4:0]            r_vs;
  logic [7:0]            r_ip;
  logic                  r_int_req;
  logic [2:0]            r_int_num;

  logic [NUM_HW_INT-1:0] w_hw_sync;
  logic                  w_cnt_wr;
  logic                  w_cmp_wr;
  logic                  w_ictl_wr;
  logic                  w_inc;
  logic [31:0]           w_count_nxt;
  logic                  w_match;
  logic [7:0]            w_ip_nxt;
  logic [7:0]            w_masked;
  logic [2:0]            w_num_nxt;
  logic                  w_req_nxt;
  logic [31:0]           w_vs_step;
  logic                  w_unused;

  cp0_int_sync #(
    .WIDTH  (NUM_HW_INT),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (hw_int_i),
    .o_q (w_hw_sync)
  );

  assign w_cnt_wr    = we_i && (waddr_i == CP0_REG_COUNT);
  assign w_cmp_wr    = we_i && (waddr_i == CP0_REG_COMPARE);
  assign w_ictl_wr   = we_i && (waddr_i == CP0_REG_INTCTL);
  assign w_inc       = !cause_dc_i && (r_presc == PW'(COUNT_DIV - 1));
  assign w_count_nxt = r_count + 32'd1;
  // Only a real tick can match; a Count write landing on Compare is silent.
  assign w_match     = w_inc && !w_cnt_wr && r_armed && (w_count_nxt == r_compare);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_armed   <= 1'b0;
      r_timer   <= 1'b0;
      r_vs      <= '0;
    end else begin
      if (w_cnt_wr) begin
        r_count <= data_i;
        r_presc <= '0;
      end else if (!cause_dc_i) begin
        r_presc <= w_inc ? '0 : r_presc + PW'(1);
        if (w_inc) r_count <= w_count_nxt;
      end

      if (w_cmp_wr) begin
        r_compare <= data_i;
        r_timer   <= 1'b0;
        r_armed   <= 1'b1;
      end else if (w_match) begin
        r_timer <= 1'b1;
      end

      if (w_ictl_wr && vs_legal(data_i[INTCTL_VS_LSB +: 5])) begin
        r_vs <= data_i[INTCTL_VS_LSB +: 5];
      end
    end
  end

  always_comb begin
    w_ip_nxt                  = '0;
    w_ip_nxt[1:0]             = sw_int_i;
    w_ip_nxt[2 +: NUM_HW_INT] = w_hw_sync;
    w_ip_nxt[TIMER_IP]        = w_ip_nxt[TIMER_IP] | r_timer;
  end

  // Masking uses the registered IP so the request lags ip_o by one cycle.
  assign w_masked  = r_ip & status_i[15:8];
  assign w_req_nxt = status_i[0] && !status_i[1] && !status_i[2] && (|w_masked);

  always_comb begin
    w_num_nxt = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_masked[i]) w_num_nxt = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ip      <= '0;
      r_int_req <= 1'b0;
      r_int_num <= '0;
    end else begin
      r_ip      <= w_ip_nxt;
      r_int_req <= w_req_nxt;
      r_int_num <= w_num_nxt;
    end
  end

  assign w_vs_step = {22'd0, r_vs, 5'd0};

  always_comb begin
    vector_offset_o = VEC_OFF_GENERAL;
    if (cause_iv_i) begin
      if (r_vs == 5'd0) vector_offset_o = VEC_OFF_IV;
      else vector_offset_o = VEC_OFF_IV + ({29'd0, r_int_num} * w_vs_step);
    end
  end

  assign count_o     = r_count;
  assign compare_o   = r_compare;
  assign intctl_o    = {3'(TIMER_IP), 19'd0, r_vs, 5'd0};
  assign ip_o        = r_ip;
  assign timer_int_o = r_timer;
  assign int_req_o   = r_int_req;
  assign int_num_o   = r_int_num;

  assign w_unused = &{1'b0, status_i[31:16], status_i[7:3]};

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: timer, prescaler, synchroniser, request and
// vector-offset behaviour with hand-computed expectations.
module tb_cp0_intc;
  import cp0_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  hw_int_i;
  logic [1:0]  sw_int_i;
  logic [31:0] status_i;
  logic        cause_iv_i;
  logic        cause_dc_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] intctl_o;
  logic [7:0]  ip_o;
  logic        timer_int_o;
  logic        int_req_o;
  logic [2:0]  int_num_o;
  logic [31:0] vector_offset_o;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  cp0_intc #(
    .NUM_HW_INT  (6),
    .SYNC_STAGES (2),
    .COUNT_DIV   (2),
    .TIMER_IP    (7)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hw_int_i        (hw_int_i),
    .sw_int_i        (sw_int_i),
    .status_i        (status_i),
    .cause_iv_i      (cause_iv_i),
    .cause_dc_i      (cause_dc_i),
    .we_i            (we_i),
    .waddr_i         (waddr_i),
    .data_i          (data_i),
    .count_o         (count_o),
    .compare_o       (compare_o),
    .intctl_o        (intctl_o),
    .ip_o            (ip_o),
    .timer_int_o     (timer_int_o),
    .int_req_o       (int_req_o),
    .int_num_o       (int_num_o),
    .vector_offset_o (vector_offset_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic cp0_write(input logic [4:0] addr, input logic [31:0] data);
    we_i    = 1'b1;
    waddr_i = addr;
    data_i  = data;
    @(negedge clk);
    we_i    = 1'b0;
    waddr_i = '0;
    data_i  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    assert_cnt++;
    if (count_o !== 32'h0) begin fail_cnt++; $display("FAIL reset_count: got %h expected %h", count_o, 32'h0); end
    assert_cnt++;
    if (compare_o !== 32'h0) begin fail_cnt++; $display("FAIL reset_compare: got %h expected %h", compare_o, 32'h0); end
    assert_cnt++;
    if (intctl_o !== 32'hE000_0000) begin fail_cnt++; $display("FAIL reset_intctl: got %h expected %h", intctl_o, 32'hE000_0000); end
    assert_cnt++;
    if ({ip_o, timer_int_o, int_req_o, int_num_o} !== 13'h0) begin
      fail_cnt++; $display("FAIL reset_irq: got ip=%h t=%b r=%b n=%0d expected all 0", ip_o, timer_int_o, int_req_o, int_num_o);
    end
    assert_cnt++;
    if (vector_offset_o !== 32'h180) begin fail_cnt++; $display("FAIL reset_vector: got %h expected %h", vector_offset_o, 32'h180); end
  endtask

  task automatic test_prescaler();
    cp0_write(CP0_REG_COUNT, 32'hFFFF_FFFE);
    assert_cnt++;
    if (count_o !== 32'hFFFF_FFFE) begin fail_cnt++; $display("FAIL count_write: got %h expected %h", count_o, 32'hFFFF_FFFE); end
    cycles(1);
    assert_cnt++;
    if (count_o !== 32'hFFFF_FFFE) begin fail_cnt++; $display("FAIL count_half: got %h expected %h", count_o, 32'hFFFF_FFFE); end
    cycles(1);
    assert_cnt++;
    if (count_o !== 32'hFFFF_FFFF) begin fail_cnt++; $display("FAIL count_inc: got %h expected %h", count_o, 32'hFFFF_FFFF); end
    cycles(2);
    assert_cnt++;
    if (count_o !== 32'h0) begin fail_cnt++; $display("FAIL count_wrap: got %h expected %h", count_o, 32'h0); end
    cause_dc_i = 1'b1;
    cycles(4);
    assert_cnt++;
    if (count_o !== 32'h0) begin fail_cnt++; $display("FAIL count_dc_hold: got %h expected %h", count_o, 32'h0); end
    cause_dc_i = 1'b0;
  endtask

  task automatic test_timer();
    bit found;
    // Count passes through Compare (both 0) while unarmed: no timer.
    cp0_write(CP0_REG_COUNT, 32'hFFFF_FFFE);
    cycles(4);
    assert_cnt++;
    if ({count_o, timer_int_o} !== {32'h0, 1'b0}) begin
      fail_cnt++; $display("FAIL unarmed_no_timer: got count=%h t=%b expected count=0 t=0", count_o, timer_int_o);
    end
    cp0_write(CP0_REG_COMPARE, 32'd5);
    cp0_write(CP0_REG_COUNT, 32'd3);
    assert_cnt++;
    if (timer_int_o !== 1'b0) begin fail_cnt++; $display("FAIL timer_early: got %b expected 0", timer_int_o); end
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycles(1);
      if (count_o == 32'd5) begin found = 1'b1; break; end
    end
    assert_cnt++;
    if (!found) begin fail_cnt++; $display("FAIL timer_count_reach: got count=%h expected 5 within 12 cycles", count_o); end
    assert_cnt++;
    if (timer_int_o !== 1'b1) begin fail_cnt++; $display("FAIL timer_match: got %b expected 1", timer_int_o); end
    cycles(3);
    assert_cnt++;
    if (timer_int_o !== 1'b1) begin fail_cnt++; $display("FAIL timer_sticky: got %b expected 1", timer_int_o); end
    cp0_write(CP0_REG_COMPARE, 32'd9);
    assert_cnt++;
    if ({compare_o, timer_int_o} !== {32'd9, 1'b0}) begin
      fail_cnt++; $display("FAIL timer_clear: got cmp=%h t=%b expected cmp=9 t=0", compare_o, timer_int_o);
    end
  endtask

  task automatic test_match_collisions();
    cp0_write(CP0_REG_COMPARE, 32'd6);
    cp0_write(CP0_REG_COUNT, 32'd5);
    cycles(1);
    // This write lands on the tick that brings Count to 6.
    cp0_write(CP0_REG_COMPARE, 32'd6);
    assert_cnt++;
    if ({count_o, timer_int_o} !== {32'd6, 1'b0}) begin
      fail_cnt++; $display("FAIL cmp_write_wins: got count=%h t=%b expected count=6 t=0", count_o, timer_int_o);
    end
    cp0_write(CP0_REG_COMPARE, 32'd5);
    cp0_write(CP0_REG_COUNT, 32'd5);
    assert_cnt++;
    if (timer_int_o !== 1'b0) begin fail_cnt++; $display("FAIL count_write_nomatch: got %b expected 0", timer_int_o); end
    cycles(4);
    assert_cnt++;
    if ({count_o, timer_int_o} !== {32'd7, 1'b0}) begin
      fail_cnt++; $display("FAIL count_write_nomatch_later: got count=%h t=%b expected count=7 t=0", count_o, timer_int_o);
    end
  endtask

  task automatic test_request();
    status_i = 32'h0000_0401;
    hw_int_i = 6'b000001;
    cycles(2);
    assert_cnt++;
    if (ip_o[2] !== 1'b0) begin fail_cnt++; $display("FAIL sync_latency_early: got %b expected 0", ip_o[2]); end
    hw_int_i = 6'b000000;
    cycles(1);
    assert_cnt++;
    if ({ip_o, int_req_o} !== {8'h04, 1'b0}) begin
      fail_cnt++; $display("FAIL ip_after3: got ip=%h r=%b expected ip=04 r=0", ip_o, int_req_o);
    end
    cycles(1);
    assert_cnt++;
    if ({int_req_o, int_num_o} !== {1'b1, 3'd2}) begin
      fail_cnt++; $display("FAIL req_after4: got r=%b n=%0d expected r=1 n=2", int_req_o, int_num_o);
    end
    hw_int_i = 6'b000001;
    cycles(4);
    status_i = 32'h0000_0403;
    cycles(1);
    assert_cnt++;
    if (int_req_o !== 1'b0) begin fail_cnt++; $display("FAIL req_exl: got %b expected 0", int_req_o); end
    status_i = 32'h0000_0401;
    cycles(1);
    assert_cnt++;
    if (int_req_o !== 1'b1) begin fail_cnt++; $display("FAIL req_reenable: got %b expected 1", int_req_o); end
    status_i = 32'h0000_0400;
    cycles(1);
    assert_cnt++;
    if (int_req_o !== 1'b0) begin fail_cnt++; $display("FAIL req_ie_clear: got %b expected 0", int_req_o); end
    hw_int_i = 6'b000000;
  endtask

  task automatic test_vector();
    status_i   = 32'h0000_FF01;
    cause_iv_i = 1'b1;
    hw_int_i   = 6'b100010;
    cp0_write(CP0_REG_INTCTL, 32'h0000_0040);
    cycles(4);
    assert_cnt++;
    if ({int_req_o, int_num_o} !== {1'b1, 3'd7}) begin
      fail_cnt++; $display("FAIL vec_num: got r=%b n=%0d expected r=1 n=7", int_req_o, int_num_o);
    end
    assert_cnt++;
    if (vector_offset_o !== 32'h3C0) begin fail_cnt++; $display("FAIL vec_vs2: got %h expected %h", vector_offset_o, 32'h3C0); end
    cp0_write(CP0_REG_INTCTL, 32'h0000_0060);
    assert_cnt++;
    if (intctl_o !== 32'hE000_0040) begin fail_cnt++; $display("FAIL vs_illegal: got %h expected %h", intctl_o, 32'hE000_0040); end
    cp0_write(CP0_REG_INTCTL, 32'h0000_0200);
    assert_cnt++;
    if (vector_offset_o !== 32'h1000) begin fail_cnt++; $display("FAIL vec_vs16: got %h expected %h", vector_offset_o, 32'h1000); end
    cp0_write(CP0_REG_INTCTL, 32'h0000_0000);
    assert_cnt++;
    if (vector_offset_o !== 32'h200) begin fail_cnt++; $display("FAIL vec_vs0: got %h expected %h", vector_offset_o, 32'h200); end
    cause_iv_i = 1'b0;
    cycles(1);
    assert_cnt++;
    if (vector_offset_o !== 32'h180) begin fail_cnt++; $display("FAIL vec_iv0: got %h expected %h", vector_offset_o, 32'h180); end
  endtask

  task automatic test_reset_pending();
    cp0_write(CP0_REG_COMPARE, 32'd10);
    cp0_write(CP0_REG_COUNT, 32'd9);
    cycles(2);
    assert_cnt++;
    if ({timer_int_o, int_req_o} !== 2'b11) begin
      fail_cnt++; $display("FAIL pre_reset_pending: got t=%b r=%b expected t=1 r=1", timer_int_o, int_req_o);
    end
    rst = 1'b1;
    cycles(1);
    assert_cnt++;
    if ({timer_int_o, int_req_o, ip_o, count_o} !== {2'b00, 8'h00, 32'h0}) begin
      fail_cnt++; $display("FAIL reset_pending: got t=%b r=%b ip=%h count=%h expected all 0", timer_int_o, int_req_o, ip_o, count_o);
    end
    assert_cnt++;
    if (intctl_o[31:29] !== 3'd7) begin fail_cnt++; $display("FAIL reset_ipti: got %0d expected 7", intctl_o[31:29]); end
    cycles(2);
    rst = 1'b0;
    cycles(1);
    assert_cnt++;
    if ({int_req_o, ip_o} !== 9'h0) begin
      fail_cnt++; $display("FAIL post_reset_no_irq: got r=%b ip=%h expected r=0 ip=00", int_req_o, ip_o);
    end
    hw_int_i = '0;
  endtask

  initial begin
    rst        = 1'b1;
    hw_int_i   = '0;
    sw_int_i   = '0;
    status_i   = '0;
    cause_iv_i = 1'b0;
    cause_dc_i = 1'b0;
    we_i       = 1'b0;
    waddr_i    = '0;
    data_i     = '0;
    @(negedge clk);
    test_reset();
    test_prescaler();
    test_reset();
    test_timer();
    test_match_collisions();
    test_request();
    test_vector();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
